// File: rtl/pll_cken_synth.sv
// pll_cken_synth: NUM_CH fractional clock-enable generators driven from one
// reference clock. Each channel strobes at refclk * NUM / DEN.
// NUM and DEN are reprogrammed through a valid/ready config port.
// Each channel reports its own lock after a settle interval.
// Optional feature macro: PLL_CKEN_PHASE_EN adds a per-channel start phase
// (cfg_phase) that is loaded into the accumulator on APPLY and on sync.
module pll_cken_synth #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 64
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
`ifdef PLL_CKEN_PHASE_EN
  input  logic [ACC_W-1:0]  cfg_phase,
`endif
  output logic              cfg_err,
  input  logic              sync,
  output logic [NUM_CH-1:0] cken,
  output logic [NUM_CH-1:0] locked,
  output logic              locked_all
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_cfg_ready;
  logic               r_cfg_err;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_ch;
  logic [ACC_W-1:0]   r_cfg_num;
  logic [ACC_W-1:0]   r_cfg_den;
  logic [NUM_CH-1:0]  r_locked;
  logic               r_locked_all;
  logic [NUM_CH-1:0]  r_cken;
  logic [ACC_W-1:0]   r_num [NUM_CH];
  logic [ACC_W-1:0]   r_den [NUM_CH];
  logic [ACC_W-1:0]   r_acc [NUM_CH];
  logic [ACC_W:0]     w_sum [NUM_CH];
  logic [ACC_W-1:0]   w_sync_load [NUM_CH];
  logic [ACC_W-1:0]   w_apply_load;
  logic [NUM_CH-1:0]  w_locked_nxt;
  logic               w_hs;
  logic               w_bad;
  logic               w_settle_done;
`ifdef PLL_CKEN_PHASE_EN
  logic [ACC_W-1:0]   r_cfg_phase;
  logic [ACC_W-1:0]   r_phase [NUM_CH];
`endif

  assign w_hs          = cfg_valid & r_cfg_ready;
  assign w_settle_done = (r_cnt == CNT_W'(LOCK_CYCLES));

  // Validate the offered configuration: bad modulus, ratio above one, or unknown channel.
  always_comb begin
    w_bad = (cfg_den == {ACC_W{1'b0}}) || (cfg_num > cfg_den) ||
            ({1'b0, cfg_ch} >= 4'(NUM_CH));
`ifdef PLL_CKEN_PHASE_EN
    if (cfg_phase >= cfg_den) begin
      w_bad = 1'b1;
    end else begin
      w_bad = w_bad;
    end
`endif
  end

  // Accumulator sums at one extra bit, plus the value an accumulator restarts from.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_num[i]};
`ifdef PLL_CKEN_PHASE_EN
      w_sync_load[i] = r_phase[i];
`else
      w_sync_load[i] = {ACC_W{1'b0}};
`endif
    end
`ifdef PLL_CKEN_PHASE_EN
    w_apply_load = r_cfg_phase;
`else
    w_apply_load = {ACC_W{1'b0}};
`endif
  end

  // Next lock vector: drop on APPLY, raise at the end of SETTLE for a running channel.
  always_comb begin
    w_locked_nxt = r_locked;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((r_state == S_APPLY) && (r_ch == 3'(i))) begin
        w_locked_nxt[i] = 1'b0;
      end else if ((r_state == S_SETTLE) && w_settle_done && (r_ch == 3'(i)) &&
                   (r_cfg_num != {ACC_W{1'b0}})) begin
        w_locked_nxt[i] = 1'b1;
      end else begin
        w_locked_nxt[i] = r_locked[i];
      end
    end
  end

  // Config FSM: handshake, reject pulse, one-cycle apply and settle countdown.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cfg_ready  <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_cnt        <= {CNT_W{1'b0}};
      r_ch         <= 3'd0;
      r_cfg_num    <= {ACC_W{1'b0}};
      r_cfg_den    <= {{(ACC_W-1){1'b0}}, 1'b1};
      r_locked     <= {NUM_CH{1'b0}};
      r_locked_all <= 1'b0;
`ifdef PLL_CKEN_PHASE_EN
      r_cfg_phase  <= {ACC_W{1'b0}};
`endif
    end else begin
      r_cfg_err    <= 1'b0;
      r_locked     <= w_locked_nxt;
      r_locked_all <= &w_locked_nxt;
      case (r_state)
        S_IDLE: begin
          r_cfg_ready <= 1'b1;
          if (w_hs) begin
            if (w_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_ch        <= cfg_ch;
              r_cfg_num   <= cfg_num;
              r_cfg_den   <= cfg_den;
`ifdef PLL_CKEN_PHASE_EN
              r_cfg_phase <= cfg_phase;
`endif
              r_cfg_ready <= 1'b0;
              r_state     <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          r_cfg_ready <= 1'b0;
          r_cnt       <= {CNT_W{1'b0}};
          r_state     <= S_SETTLE;
        end
        S_SETTLE: begin
          if (w_settle_done) begin
            r_cfg_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cfg_ready <= 1'b0;
            r_cnt       <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cfg_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Per-channel phase accumulators and strobe generation; APPLY and sync restart phase.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_cken <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        r_num[i] <= {ACC_W{1'b0}};
        r_den[i] <= {{(ACC_W-1){1'b0}}, 1'b1};
        r_acc[i] <= {ACC_W{1'b0}};
`ifdef PLL_CKEN_PHASE_EN
        r_phase[i] <= {ACC_W{1'b0}};
`endif
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((r_state == S_APPLY) && (r_ch == 3'(i))) begin
          r_num[i]  <= r_cfg_num;
          r_den[i]  <= r_cfg_den;
          r_acc[i]  <= w_apply_load;
          r_cken[i] <= 1'b0;
`ifdef PLL_CKEN_PHASE_EN
          r_phase[i] <= r_cfg_phase;
`endif
        end else if (sync) begin
          r_acc[i]  <= w_sync_load[i];
          r_cken[i] <= 1'b0;
        end else if (r_num[i] != {ACC_W{1'b0}}) begin
          if (w_sum[i] >= {1'b0, r_den[i]}) begin
            r_acc[i]  <= ACC_W'(w_sum[i] - {1'b0, r_den[i]});
            r_cken[i] <= 1'b1;
          end else begin
            r_acc[i]  <= ACC_W'(w_sum[i]);
            r_cken[i] <= 1'b0;
          end
        end else begin
          r_cken[i] <= 1'b0;
        end
      end
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign cfg_err    = r_cfg_err;
  assign cken       = r_cken;
  assign locked     = r_locked;
  assign locked_all = r_locked_all;

endmodule
